// File: rtl/ofdm_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_pkg
// Shared definitions for the OFDM cyclic-prefix transmit chain.
// Holds the scheduler state encoding and the default geometry constants
// (FFT size, CP length, address width) used by the CP and FFT blocks.
// ---------------------------------------------------------------------------
package ofdm_pkg;

  localparam int NFFT_DEFAULT = 64;
  localparam int NCP_DEFAULT  = 16;
  localparam int AW_DEFAULT   = 6;
  localparam int GAP_DEFAULT  = 4;
  localparam int SW_DEFAULT   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ofdm_sym_sched_sym_cnt.sv
// ---------------------------------------------------------------------------
// sym_cnt
// Loadable wrap counter with enable and terminal-count flag.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   load     - synchronous load of load_val (highest priority after reset)
//   load_val - value taken on load
//   adv      - advance: count up, wrapping to 0 after reaching 'last'
//   last     - terminal value
//   cnt      - current count
//   tc       - high while cnt equals 'last'
// ---------------------------------------------------------------------------
module sym_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         adv,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (adv) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ofdm_sym_sched.sv
// ---------------------------------------------------------------------------
// ofdm_sym_sched
// Symbol scheduler for the OFDM CP-insertion chain. Emits each symbol as
// NCP cyclic-prefix samples (tail of the body) followed by the NFFT body
// samples, sequences a frame of cfg_nsym symbols with an optional idle gap,
// and stalls on downstream backpressure.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   start      - frame start request, honoured only in IDLE
//   abort      - synchronous abort back to IDLE
//   cfg_nsym   - symbols per frame, latched on an accepted start
//   ready      - downstream can take a sample this cycle
//   en         - chain enable / sample valid
//   sop, eop   - first CP sample / last body sample of a symbol
//   cp_phase   - current sample belongs to the cyclic prefix
//   rd_addr    - sample buffer read address
//   sym_idx    - 0-based index of the current symbol
//   busy       - any state other than IDLE
//   frame_done - one-cycle pulse after the final eop
// ---------------------------------------------------------------------------
module ofdm_sym_sched
  import ofdm_pkg::*;
#(
  parameter int NFFT = NFFT_DEFAULT,
  parameter int NCP  = NCP_DEFAULT,
  parameter int GAP  = GAP_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int SW   = SW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] cfg_nsym,
  input  logic          ready,
  output logic          en,
  output logic          sop,
  output logic          eop,
  output logic          cp_phase,
  output logic [AW-1:0] rd_addr,
  output logic [SW-1:0] sym_idx,
  output logic          busy,
  output logic          frame_done
);

  // One extra bit over the widest terminal value so every terminal fits.
  localparam int CW = max_int(AW, $clog2(GAP)) + 1;

  localparam logic [CW-1:0] CP_LAST   = CW'(NCP - 1);
  localparam logic [CW-1:0] BODY_LAST = CW'(NFFT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [AW-1:0] CP_BASE   = AW'(NFFT - NCP);

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] nsym_q;
  logic [CW-1:0] s_cnt;
  logic [CW-1:0] s_last;
  logic          s_tc;
  logic          s_adv;
  logic [SW-1:0] y_cnt;
  logic          y_tc;
  logic          y_adv;
  logic          start_ok;
  logic          abort_hit;
  logic          cnt_clr;

  assign start_ok  = (state_q == ST_IDLE) && start && (cfg_nsym != '0);
  assign abort_hit = (state_q != ST_IDLE) && abort;
  assign cnt_clr   = start_ok || abort_hit;

  // Sample counter: the terminal value follows the phase being emitted.
  // It only moves on accepted samples, except in GAP where it free-runs.
  always_comb begin
    s_last = BODY_LAST;
    case (state_q)
      ST_CP:   s_last = CP_LAST;
      ST_GAP:  s_last = GAP_LAST;
      default: s_last = BODY_LAST;
    endcase
  end

  assign s_adv = en || (state_q == ST_GAP);

  sym_cnt #(.W(CW)) u_sample_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_clr),
    .load_val ('0),
    .adv      (s_adv),
    .last     (s_last),
    .cnt      (s_cnt),
    .tc       (s_tc)
  );

  // Symbol counter steps when the next symbol's CP begins: at the end of
  // the gap, or straight out of the body when there is no gap. It is never
  // stepped past the final symbol, so sym_idx holds through DONE.
  assign y_adv = ((state_q == ST_GAP) && s_tc) ||
                 ((GAP == 0) && (state_q == ST_BODY) && en && s_tc && !y_tc);

  sym_cnt #(.W(SW)) u_symbol_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_clr),
    .load_val ('0),
    .adv      (y_adv),
    .last     (nsym_q - 1'b1),
    .cnt      (y_cnt),
    .tc       (y_tc)
  );

  // Frame length is captured once so cfg_nsym may change mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nsym_q <= '0;
    end else if (abort_hit) begin
      nsym_q <= '0;
    end else if (start_ok) begin
      nsym_q <= cfg_nsym;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_ok) state_d = ST_CP;
        ST_CP:   if (en && s_tc) state_d = ST_BODY;
        ST_BODY: begin
          if (en && s_tc) begin
            if (y_tc)         state_d = ST_DONE;
            else if (GAP > 0) state_d = ST_GAP;
            else              state_d = ST_CP;
          end
        end
        ST_GAP:  if (s_tc) state_d = ST_CP;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs; en passes ready through in the emitting phases so a
  // stalled sample keeps its address and framing until it is taken.
  always_comb begin
    en         = 1'b0;
    sop        = 1'b0;
    eop        = 1'b0;
    cp_phase   = 1'b0;
    rd_addr    = '0;
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DONE);
    case (state_q)
      ST_CP: begin
        en       = ready;
        cp_phase = 1'b1;
        sop      = (s_cnt == '0);
        rd_addr  = CP_BASE + s_cnt[AW-1:0];
      end
      ST_BODY: begin
        en      = ready;
        eop     = (s_cnt == BODY_LAST);
        rd_addr = s_cnt[AW-1:0];
      end
      default: ;
    endcase
  end

  assign sym_idx = y_cnt;

endmodule
